// File: rtl/niu32_mmio_ctrl.sv
// MMIO controller for the Niu32 core: LED/HEX output registers, synchronised and
// debounced KEY/SWITCH inputs, and sticky key-press flags in the 0xFFFF_xxxx window.
module niu32_mmio_ctrl #(
  parameter int                    WORD_SIZE    = 32,
  parameter logic [15:0]           DEB_CYCLES   = 16'd50000,
  parameter int                    DEB_BITS     = 16,
  parameter logic [WORD_SIZE-1:0]  ADDR_HEX     = 32'hFFFF0000,
  parameter logic [WORD_SIZE-1:0]  ADDR_LEDR    = 32'hFFFF0020,
  parameter logic [WORD_SIZE-1:0]  ADDR_LEDG    = 32'hFFFF0040,
  parameter logic [WORD_SIZE-1:0]  ADDR_KEY     = 32'hFFFF0100,
  parameter logic [WORD_SIZE-1:0]  ADDR_KEYEDGE = 32'hFFFF0104,
  parameter logic [WORD_SIZE-1:0]  ADDR_SWITCH  = 32'hFFFF0120
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic                 io_sel,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 rd_valid,
  input  logic [3:0]           key_raw,
  input  logic [9:0]           switch_raw,
  output logic [15:0]          hex_val,
  output logic [9:0]           ledr,
  output logic [7:0]           ledg
);

  localparam int NIN = 14;
  localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEB_CYCLES - 16'd1);

  logic [3:0]          key_meta_p0, key_sync_p1;
  logic [9:0]          sw_meta_p0, sw_sync_p1;
  logic [NIN-1:0]      in_sync;
  logic [NIN-1:0]      db, db_next;
  logic [DEB_BITS-1:0] cnt [NIN];
  logic [3:0]          flags, flags_next, edge_clr;
  logic [WORD_SIZE-1:0] rd_mux;
  logic                wr_hex, wr_ledr, wr_ledg, wr_kedge;
  logic                unused_ok;

  assign unused_ok = ^wdata[WORD_SIZE-1:16];

  assign io_sel = (addr[WORD_SIZE-1 -: 16] == 16'hFFFF);

  assign wr_hex   = wr_en && (addr == ADDR_HEX);
  assign wr_ledr  = wr_en && (addr == ADDR_LEDR);
  assign wr_ledg  = wr_en && (addr == ADDR_LEDG);
  assign wr_kedge = wr_en && (addr == ADDR_KEYEDGE);

  // Keys are active-low on the board; invert after the synchroniser so pressed = 1.
  assign in_sync = {sw_sync_p1, ~key_sync_p1};

  // Stage p0/p1: two-flop synchronisers
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_p0 <= 4'hF;
      key_sync_p1 <= 4'hF;
      sw_meta_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      key_meta_p0 <= key_raw;
      key_sync_p1 <= key_meta_p0;
      sw_meta_p0  <= switch_raw;
      sw_sync_p1  <= sw_meta_p0;
    end
  end

  always_comb begin
    db_next = db;
    for (int i = 0; i < NIN; i++) begin
      if ((in_sync[i] != db[i]) && (cnt[i] == DEB_LAST)) db_next[i] = in_sync[i];
    end
  end

  // Set takes priority over a simultaneous write-1-to-clear.
  assign edge_clr   = wr_kedge ? wdata[3:0] : 4'b0;
  assign flags_next = (flags & ~edge_clr) | (db_next[3:0] & ~db[3:0]);

  // Stage p2: debounce counters, debounced state and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      db    <= '0;
      flags <= '0;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      db    <= db_next;
      flags <= flags_next;
      for (int i = 0; i < NIN; i++) begin
        if ((in_sync[i] == db[i]) || (cnt[i] == DEB_LAST)) cnt[i] <= '0;
        else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_val <= '0;
      ledr    <= '0;
      ledg    <= '0;
    end else begin
      if (wr_hex)  hex_val <= wdata[15:0];
      if (wr_ledr) ledr    <= wdata[9:0];
      if (wr_ledg) ledg    <= wdata[7:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_HEX:     rd_mux = WORD_SIZE'(hex_val);
      ADDR_LEDR:    rd_mux = WORD_SIZE'(ledr);
      ADDR_LEDG:    rd_mux = WORD_SIZE'(ledg);
      ADDR_KEY:     rd_mux = WORD_SIZE'(db[3:0]);
      ADDR_KEYEDGE: rd_mux = WORD_SIZE'(flags);
      ADDR_SWITCH:  rd_mux = WORD_SIZE'(db[13:4]);
      default:      rd_mux = '0;
    endcase
  end

  // Read response: samples pre-write state, holds until the next read
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_niu32_mmio_ctrl.sv
// Randomised and directed bench for niu32_mmio_ctrl with a behavioural model
// built from sampled-input history rather than per-bit counters.
module tb_niu32_mmio_ctrl;

  localparam int DEB = 4;
  localparam logic [31:0] A_HEX   = 32'hFFFF0000;
  localparam logic [31:0] A_LEDR  = 32'hFFFF0020;
  localparam logic [31:0] A_LEDG  = 32'hFFFF0040;
  localparam logic [31:0] A_KEY   = 32'hFFFF0100;
  localparam logic [31:0] A_KEDGE = 32'hFFFF0104;
  localparam logic [31:0] A_SW    = 32'hFFFF0120;

  logic        clk, reset, wr_en, rd_en, io_sel, rd_valid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  key_raw;
  logic [9:0]  switch_raw, ledr;
  logic [15:0] hex_val;
  logic [7:0]  ledg;

  niu32_mmio_ctrl #(.DEB_CYCLES(16'(DEB))) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wr_en(wr_en),
    .rd_en(rd_en), .io_sel(io_sel), .rdata(rdata), .rd_valid(rd_valid),
    .key_raw(key_raw), .switch_raw(switch_raw), .hex_val(hex_val),
    .ledr(ledr), .ledg(ledg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a debounced bit flips once the last DEB synchronised
  // samples all disagree with it.
  logic [3:0]  m_k1, m_k2;
  logic [9:0]  m_s1, m_s2;
  logic [13:0] m_db;
  logic [13:0] m_hist [DEB];
  logic [3:0]  m_flags;
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;
  logic [31:0] m_rdata;
  logic        m_rvalid;

  function automatic logic [31:0] mread(input logic [31:0] a);
    case (a)
      A_HEX:   return {16'b0, m_hex};
      A_LEDR:  return {22'b0, m_ledr};
      A_LEDG:  return {24'b0, m_ledg};
      A_KEY:   return {28'b0, m_db[3:0]};
      A_KEDGE: return {28'b0, m_flags};
      A_SW:    return {22'b0, m_db[13:4]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [13:0] samp, newdb;
    logic [3:0]  clr;
    bit          all_diff;
    if (reset) begin
      m_k1 = 4'hF; m_k2 = 4'hF; m_s1 = '0; m_s2 = '0;
      m_db = '0; m_flags = '0; m_hex = '0; m_ledr = '0; m_ledg = '0;
      m_rdata = '0; m_rvalid = 1'b0;
      for (int j = 0; j < DEB; j++) m_hist[j] = '0;
    end else begin
      if (rd_en) m_rdata = mread(addr);
      m_rvalid = rd_en;
      if (wr_en && addr == A_HEX)  m_hex  = wdata[15:0];
      if (wr_en && addr == A_LEDR) m_ledr = wdata[9:0];
      if (wr_en && addr == A_LEDG) m_ledg = wdata[7:0];
      clr = (wr_en && addr == A_KEDGE) ? wdata[3:0] : 4'h0;
      samp = {m_s2, ~m_k2};
      for (int j = DEB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = samp;
      newdb = m_db;
      for (int b = 0; b < 14; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) if (m_hist[j][b] == m_db[b]) all_diff = 1'b0;
        if (all_diff) newdb[b] = samp[b];
      end
      m_flags = (m_flags & ~clr) | (newdb[3:0] & ~m_db[3:0]);
      m_db = newdb;
      m_k2 = m_k1; m_k1 = key_raw;
      m_s2 = m_s1; m_s1 = switch_raw;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_rvalid});
      chk("rdata", rdata, m_rdata);
      chk("hex_val", {16'b0, hex_val}, {16'b0, m_hex});
      chk("ledr", {22'b0, ledr}, {22'b0, m_ledr});
      chk("ledg", {24'b0, ledg}, {24'b0, m_ledg});
      chk("io_sel", {31'b0, io_sel}, {31'b0, addr[31:16] == 16'hFFFF});
    end
  end

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we, input logic re);
    addr = a; wdata = d; wr_en = we; rd_en = re;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  logic [31:0] addr_tab [10];
  logic [31:0] a6 [6];

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0;
    key_raw = 4'hF; switch_raw = '0;
    addr_tab = '{A_HEX, A_LEDR, A_LEDG, A_KEY, A_KEDGE, A_SW,
                 32'hFFFF0008, 32'hFFFF0124, 32'h00000010, 32'h1234FFFF};
    a6 = '{A_HEX, A_LEDR, A_LEDG, A_KEY, A_KEDGE, A_SW};
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    reset = 1'b0;
    chk("hex_rst", {16'b0, hex_val}, 32'h0);

    foreach (a6[i]) begin
      cyc(a6[i], 32'h0, 1'b0, 1'b1);
      chk("rd_after_rst", rdata, 32'h0);
      chk("rdv_pulse", {31'b0, rd_valid}, 32'h1);
    end
    idle(1);
    chk("rdv_low", {31'b0, rd_valid}, 32'h0);

    cyc(A_HEX,  32'hDEADBEEF, 1'b1, 1'b0);
    cyc(A_LEDR, 32'hDEADBEEF, 1'b1, 1'b0);
    cyc(A_LEDG, 32'hDEADBEEF, 1'b1, 1'b0);
    cyc(A_SW,   32'hDEADBEEF, 1'b1, 1'b0);
    chk("hex_wr",  {16'b0, hex_val}, 32'h0000BEEF);
    chk("ledr_wr", {22'b0, ledr}, 32'h000002EF);
    chk("ledg_wr", {24'b0, ledg}, 32'h000000EF);
    cyc(A_HEX, 32'h0, 1'b0, 1'b1);  chk("hex_rd", rdata, 32'h0000BEEF);
    cyc(A_LEDR, 32'h0, 1'b0, 1'b1); chk("ledr_rd", rdata, 32'h000002EF);
    cyc(A_SW, 32'h0, 1'b0, 1'b1);   chk("sw_rd_ro", rdata, 32'h0);

    // Read and write in the same cycle returns the old value
    cyc(A_LEDG, 32'h00000012, 1'b1, 1'b1);
    chk("rw_same_cycle", rdata, 32'h000000EF);

    // Key 0 press: debounced exactly 2+DEB edges later
    key_raw[0] = 1'b0;
    idle(5);
    cyc(A_KEY, 32'h0, 1'b0, 1'b1);   chk("key_edge6_pre", rdata, 32'h0);
    cyc(A_KEY, 32'h0, 1'b0, 1'b1);   chk("key_pressed", rdata, 32'h1);
    cyc(A_KEDGE, 32'h0, 1'b0, 1'b1); chk("kedge_set", rdata, 32'h1);

    // Three-cycle glitch on key 1 is rejected
    key_raw[1] = 1'b0;
    idle(3);
    key_raw[1] = 1'b1;
    idle(8);
    cyc(A_KEY, 32'h0, 1'b0, 1'b1);   chk("glitch_reject", rdata, 32'h1);

    // Release key 0, then re-press with a W1C landing on the rising edge
    key_raw[0] = 1'b1;
    idle(8);
    key_raw[0] = 1'b0;
    idle(5);
    cyc(A_KEDGE, 32'h1, 1'b1, 1'b0);
    cyc(A_KEDGE, 32'h0, 1'b0, 1'b1); chk("set_wins", rdata, 32'h1);
    cyc(A_KEDGE, 32'h1, 1'b1, 1'b0);
    cyc(A_KEDGE, 32'h0, 1'b0, 1'b1); chk("w1c_clear", rdata, 32'h0);

    switch_raw = 10'h3A5;
    idle(5);
    cyc(A_SW, 32'h0, 1'b0, 1'b1);    chk("sw_pre", rdata, 32'h0);
    cyc(A_SW, 32'h0, 1'b0, 1'b1);    chk("sw_db", rdata, 32'h000003A5);
    cyc(32'h00000010, 32'hFFFFFFFF, 1'b1, 1'b1);
    chk("io_sel_off", {31'b0, io_sel}, 32'h0);
    chk("nonio_rd", rdata, 32'h0);

    // Reset while key 2's counter sits at DEB-1
    key_raw[2] = 1'b0;
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("hex_after_rst", {16'b0, hex_val}, 32'h0);
    cyc(A_KEY, 32'h0, 1'b0, 1'b1);   chk("key_after_rst", rdata, 32'h0);
    cyc(A_KEDGE, 32'h0, 1'b0, 1'b1); chk("kedge_after_rst", rdata, 32'h0);
    idle(3);
    cyc(A_KEY, 32'h0, 1'b0, 1'b1);   chk("key_full_count_pre", rdata, 32'h0);
    cyc(A_KEY, 32'h0, 1'b0, 1'b1);   chk("key_full_count", rdata, 32'h5);

    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 39) == 0) key_raw[b] = ~key_raw[b];
      for (int b = 0; b < 10; b++) if ($urandom_range(0, 39) == 0) switch_raw[b] = ~switch_raw[b];
      reset = ($urandom_range(0, 599) == 0);
      cyc(addr_tab[$urandom_range(0, 9)], $urandom, ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 1) == 0));
    end
    reset = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
